// File: rtl/bit_pack_pkg.sv
// Shared helpers for the bit_pack_pipe slice: counter sizing and channel
// slice placement within the packed word bus.
package bit_pack_pkg;

    // Width of the shared bit counter; never narrower than one bit.
    function automatic int cnt_width(input int word_w);
        return (word_w <= 2) ? 1 : $clog2(word_w);
    endfunction

    // LSB position of channel c inside a bus of word_w-bit channel words.
    function automatic int chan_lsb(input int c, input int word_w);
        return c * word_w;
    endfunction

endpackage

// File: rtl/bit_delay_line.sv
// Fixed-latency shift register: every stage advances each cycle, valid or not.
module bit_delay_line
    import bit_pack_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_p[i] <= '0;
            end
        end else begin
            stage_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_p[i] <= stage_p[i-1];
            end
        end
    end

    assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/bit_pack_pipe.sv
// Multi-lane bit delay line with optional inversion, feeding a per-channel
// serial-to-word packer behind a single-entry valid/ready holding register.
module bit_pack_pipe
    import bit_pack_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 3,
    parameter int WORD_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [CHANNELS-1:0]        in_bits,
    input  logic                       mode,
    output logic                       out_valid,
    output logic [CHANNELS-1:0]        out_bits,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [CHANNELS*WORD_W-1:0] word_data,
    output logic                       overflow
);

    localparam int                CNT_W    = cnt_width(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [CHANNELS:0]          dl_in_p0;
    logic [CHANNELS:0]          dl_out_p1;
    logic [CNT_W-1:0]           cnt_p1;
    logic [CHANNELS*WORD_W-1:0] acc_p1;
    logic [CHANNELS*WORD_W-1:0] word_next;
    logic                       word_done;
    logic                       xfer;

    // Stage 0: inversion is folded in before the delay so mode travels with its bits
    assign dl_in_p0 = {in_valid, in_bits ^ {CHANNELS{mode}}};

    bit_delay_line #(
        .WIDTH (CHANNELS + 1),
        .DEPTH (DEPTH)
    ) u_delay_line (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in_p0),
        .dout (dl_out_p1)
    );

    assign out_valid = dl_out_p1[CHANNELS];
    assign out_bits  = dl_out_p1[CHANNELS-1:0];

    // Packer: merge the incoming bit column into the accumulator at position cnt
    always_comb begin
        word_next = acc_p1;
        if (out_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int b = 0; b < WORD_W; b++) begin
                    if (cnt_p1 == CNT_W'(b)) begin
                        word_next[chan_lsb(c, WORD_W) + b] = out_bits[c];
                    end
                end
            end
        end
    end

    assign word_done = out_valid && (cnt_p1 == CNT_LAST);
    assign xfer      = word_valid && word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
            acc_p1 <= '0;
        end else if (out_valid) begin
            acc_p1 <= word_next;
            cnt_p1 <= word_done ? '0 : cnt_p1 + CNT_W'(1);
        end
    end

    // Holding register: a completing word is taken only if the slot is free or draining
    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid <= 1'b0;
            word_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (word_done && (!word_valid || xfer)) begin
                word_valid <= 1'b1;
                word_data  <= word_next;
            end else if (xfer) begin
                word_valid <= 1'b0;
            end
            if (word_done && word_valid && !word_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bit_pack_pipe.md
# bit_pack_pipe

Parametrised multi-channel bit pipeline with a fixed-latency delay line, optional inversion, and per-channel serial-to-word packing behind a valid/ready holding register. It generalises the single-bit inverter chain and byte capture to CHANNELS lanes, configurable depth and word width. It adds backpressure and overflow detection. It sits between single-bit stimulus sources and word-wide consumers in the coverage test fabric.

## Interface
- CHANNELS, 4, number of parallel bit lanes (>=1)
- DEPTH, 3, delay-line stages (>=1)
- WORD_W, 8, bits packed per channel word (>=2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_bits valid this cycle
- in_bits  input  CHANNELS  one bit per channel
- mode  input  1  0 = pass, 1 = invert (applied at delay-line input)
- out_valid  output  1  delayed in_valid
- out_bits  output  CHANNELS  delayed, optionally inverted bits
- word_valid  output  1  holding register full
- word_ready  input  1  consumer accepts word
- word_data  output  CHANNELS*WORD_W  channel c at [c*WORD_W +: WORD_W]
- overflow  output  1  sticky: a completed word was dropped

## Operation
- Delay line:
  - Stage 0 loads {in_valid, in_bits ^ {CHANNELS{mode}}} every cycle.
  - Each stage shifts every cycle regardless of valid.
  - out_valid and out_bits are driven by stage DEPTH-1.
  - mode is sampled with the bits, so a mode change affects only bits entering on or after that edge.
- Packer consumes the delayed stream (out_valid/out_bits):
  - Shared bit counter cnt, 0..WORD_W-1. Per-channel shift accumulator.
  - On out_valid, bit k of the current word is written to position cnt; the first bit lands at LSB.
  - If cnt==WORD_W-1, the word completes and cnt wraps to 0. Otherwise cnt increments.
- Holding register with word_valid/word_ready handshake:
  - Transfer occurs on any edge with word_valid && word_ready. word_valid clears unless a new word completes on the same edge.
  - Completion while empty, or while a transfer occurs: load the word, word_valid=1.
  - Completion while full and no transfer: word dropped, holding register unchanged, overflow set.
  - overflow is cleared only by rst.
- word_data is stable while word_valid=1 and not transferred.

## Timing
- Reset (rst high at an edge) clears:
  - all delay stages
  - cnt and accumulators
  - the holding register
  - all outputs: out_valid=0, out_bits=0, word_valid=0, word_data=0, overflow=0
- Reset mid-word discards the partial word. The next valid bit after reset is bit 0.
- out_* latency is exactly DEPTH cycles: input sampled at edge n appears from edge n+DEPTH-1.
- Word latency: with the first bit presented in cycle 0 and valid every cycle, word_valid rises in cycle DEPTH+WORD_W.
- Gaps in in_valid stretch the word. No timeout applies.
- Back-to-back words are sustained at one bit per cycle if word_ready is held high.
- word_ready has no combinational path to any output.

## Structure
- Package bit_pack_pkg holds:
  - CNT_W = $clog2(WORD_W)
  - a helper function computing the channel slice offset
- Sub-module bit_delay_line: parametrised width = CHANNELS+1 and DEPTH, synchronous reset. It is instantiated once.
- Packer and holding register stay in the top module.

## Test plan
Bench configuration: CHANNELS=2, DEPTH=3, WORD_W=8.
- Reset: assert rst for 2 cycles with random inputs -> every output is 0 one edge later and stays 0 while rst is high.
- Latency: mode=0, in_valid=1, in_bits=2'b01 in cycle 0 only -> out_valid=1 and out_bits=2'b01 in cycle 3 only.
- Invert/mode switch: mode=1 for cycle 0 and mode=0 for cycle 1, in_bits=2'b01 both cycles -> out_bits=2'b10 in cycle 3, then 2'b01 in cycle 4.
- Pack: valid for 8 cycles, ch0 bits 1,0,1,0,0,0,0,0 and ch1 all 1, word_ready=1 -> word_data=16'hFF05 with word_valid for one cycle in cycle 11.
- Backpressure/overflow: word_ready=0 during 16 valid bits, first word 0x0011, second word 0x00EE -> word_data stays 0x0011, overflow=1 after the 16th bit. Raising word_ready clears word_valid next edge while overflow stays 1.
- Reset mid-word: 5 valid bits, 1-cycle rst, then 8 bits forming 0xA5 on both channels -> word_data=16'hA5A5 and overflow=0.
